serial_word_comparator: RTL



---
 rtl/serial_word_comparator_if.sv | 24 ++
 rtl/serial_word_comparator.sv | 108 ++++++++++
 2 files changed

// File: rtl/serial_word_comparator_if.sv
// Start/result bundle for serial_word_comparator: operands and start go in; busy,
// done and the eq/gt/lt verdict come back.
interface serial_word_comparator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, a_in, b_in,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, eq, gt, lt
  );
endinterface

// File: rtl/serial_word_comparator.sv
// Bit-serial, MSB-first unsigned magnitude/equality comparator with start/busy/done.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit pair.
module serial_word_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_word_comparator_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             gt_acc_q, gt_acc_d, lt_acc_q, lt_acc_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic             msb_a, msb_b, bit_eq, finish;

  assign msb_a  = sa_q[WIDTH-1];
  assign msb_b  = sb_q[WIDTH-1];
  assign bit_eq = (~msb_a & ~msb_b) | (msb_a & msb_b);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign finish = (cnt_q == '0) || (!decided_q && !bit_eq);
`else
  assign finish = (cnt_q == '0);
`endif

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_acc_d  = gt_acc_q;
    lt_acc_d  = lt_acc_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sa_d      = bus.a_in;
          sb_d      = bus.b_in;
          cnt_d     = CntW'(WIDTH - 1);
          decided_d = 1'b0;
          gt_acc_d  = 1'b0;
          lt_acc_d  = 1'b0;
          state_d   = StCompare;
        end
      end
      StCompare: begin
        // The first differing bit pair fixes the verdict; later bits are ignored.
        if (!decided_q && !bit_eq) begin
          decided_d = 1'b1;
          gt_acc_d  = msb_a;
          lt_acc_d  = msb_b;
        end
        sa_d = sa_q << 1;
        sb_d = sb_q << 1;
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        if (finish) begin
          eq_d    = ~decided_d;
          gt_d    = gt_acc_d;
          lt_d    = lt_acc_d;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_acc_q  <= 1'b0;
      lt_acc_q  <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_acc_q  <= gt_acc_d;
      lt_acc_q  <= lt_acc_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign bus.busy = (state_q == StCompare);
  assign bus.done = (state_q == StDone);
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
endmodule
